// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared opcodes, FSM states and default sizes for the load/store unit
package dmem_lsu_pkg;
  localparam int LSU_ADDR_W = 4;
  localparam int LSU_DATA_W = 8;
  localparam int LSU_DEPTH = 16;
  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STORE   = 3'd1,
    S_LOAD_RD = 3'd2,
    S_DUMP_RD = 3'd3,
    S_RSP     = 3'd4
  } state_t;
endpackage

// File: rtl/dmem_lsu_dump_cnt.sv
// dmem_lsu_dump_cnt: DUMP beat counter with clear, non-wrapping increment and last flag
module dmem_lsu_dump_cnt #(
  parameter int ADDR_W = 4,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt,
  output logic              last
);
  assign last = (cnt == ADDR_W'(DEPTH - 1));
  // Count beats; saturates at the final address instead of wrapping
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && !last) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store/dump initiator for a 16x8 async-read memory; DMEM_LSU_STATS_EN adds LoadCount/StoreCount
import dmem_lsu_pkg::*;
module dmem_lsu #(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W,
  parameter int DEPTH = LSU_DEPTH
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [1:0]        ReqOp,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic [ADDR_W-1:0] RspAddr,
  output logic              RspLast,
  output logic              RspErr,
`ifdef DMEM_LSU_STATS_EN
  output logic [7:0]        LoadCount,
  output logic [7:0]        StoreCount,
`endif
  output logic [ADDR_W-1:0] MemReadSelect,
  input  logic [DATA_W-1:0] MemDataOut,
  output logic              MemWriteEn,
  output logic [ADDR_W-1:0] MemWriteSelect,
  output logic [DATA_W-1:0] MemDataIn
);
  state_t state, state_n;
  logic dump, dump_n, req_fire, cnt_clr, cnt_inc, cnt_last;
  logic rsp_valid_n, rsp_last_n, rsp_err_n, we_n;
  logic [ADDR_W-1:0] cnt, rd_sel_n, rsp_addr_n, wsel_n;
  logic [DATA_W-1:0] rsp_data_n, wdata_n;
  assign req_fire = ReqValid && ReqReady;
  dmem_lsu_dump_cnt #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_cnt (
    .clk(Clock), .rst(Reset), .clr(cnt_clr), .inc(cnt_inc), .cnt(cnt), .last(cnt_last)
  );
  // Next-state and next-output logic; every output is then registered
  always_comb begin
    state_n = state;
    dump_n = dump;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    we_n = 1'b0;
    wsel_n = MemWriteSelect;
    wdata_n = MemDataIn;
    rd_sel_n = MemReadSelect;
    rsp_valid_n = RspValid;
    rsp_data_n = RspData;
    rsp_addr_n = RspAddr;
    rsp_last_n = RspLast;
    rsp_err_n = RspErr;
    case (state)
      S_IDLE: if (req_fire) begin
        dump_n = 1'b0;
        case (ReqOp)
          OP_LOAD: begin
            rd_sel_n = ReqAddr;
            state_n = S_LOAD_RD;
          end
          OP_STORE: begin
            we_n = 1'b1;
            wsel_n = ReqAddr;
            wdata_n = ReqData;
            state_n = S_STORE;
          end
          OP_DUMP: begin
            cnt_clr = 1'b1;
            rd_sel_n = '0;
            dump_n = 1'b1;
            state_n = S_DUMP_RD;
          end
          default: begin
            rsp_valid_n = 1'b1;
            rsp_err_n = 1'b1;
            rsp_last_n = 1'b1;
            rsp_data_n = '0;
            rsp_addr_n = ReqAddr;
            state_n = S_RSP;
          end
        endcase
      end
      S_STORE: state_n = S_IDLE;
      S_LOAD_RD, S_DUMP_RD: begin
        rsp_valid_n = 1'b1;
        rsp_data_n = MemDataOut;
        rsp_addr_n = MemReadSelect;
        rsp_last_n = (state == S_LOAD_RD) ? 1'b1 : cnt_last;
        rsp_err_n = 1'b0;
        state_n = S_RSP;
      end
      S_RSP: if (RspReady) begin
        rsp_valid_n = 1'b0;
        rsp_last_n = 1'b0;
        rsp_err_n = 1'b0;
        if (dump && !cnt_last) begin
          cnt_inc = 1'b1;
          rd_sel_n = cnt + 1'b1;
          state_n = S_DUMP_RD;
        end else begin
          dump_n = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
  // State and output registers
  always_ff @(posedge Clock)
    if (Reset) begin
      state <= S_IDLE;
      dump <= 1'b0;
      ReqReady <= 1'b1;
      RspValid <= 1'b0;
      RspData <= '0;
      RspAddr <= '0;
      RspLast <= 1'b0;
      RspErr <= 1'b0;
      MemReadSelect <= '0;
      MemWriteEn <= 1'b0;
      MemWriteSelect <= '0;
      MemDataIn <= '0;
    end else begin
      state <= state_n;
      dump <= dump_n;
      ReqReady <= (state_n == S_IDLE);
      RspValid <= rsp_valid_n;
      RspData <= rsp_data_n;
      RspAddr <= rsp_addr_n;
      RspLast <= rsp_last_n;
      RspErr <= rsp_err_n;
      MemReadSelect <= rd_sel_n;
      MemWriteEn <= we_n;
      MemWriteSelect <= wsel_n;
      MemDataIn <= wdata_n;
    end
`ifdef DMEM_LSU_STATS_EN
  // Saturating counts of accepted LOADs and STOREs
  always_ff @(posedge Clock)
    if (Reset) begin
      LoadCount <= '0;
      StoreCount <= '0;
    end else begin
      if (req_fire && ReqOp == OP_LOAD && LoadCount != 8'hFF) LoadCount <= LoadCount + 1'b1;
      if (req_fire && ReqOp == OP_STORE && StoreCount != 8'hFF) StoreCount <= StoreCount + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu with a 16x8 async-read / sync-write memory model
import dmem_lsu_pkg::*;
module tb_dmem_lsu;
  logic Clock = 1'b0;
  logic Reset, ReqValid, ReqReady, RspValid, RspReady, RspLast, RspErr, MemWriteEn;
  logic [1:0] ReqOp;
  logic [3:0] ReqAddr, RspAddr, MemReadSelect, MemWriteSelect;
  logic [7:0] ReqData, RspData, MemDataOut, MemDataIn;
`ifdef DMEM_LSU_STATS_EN
  logic [7:0] LoadCount, StoreCount;
`endif
  logic [7:0] mem [16];
  logic [7:0] exp_mem [16];
  int tests = 0;
  int fails = 0;
  always #5 Clock = ~Clock;
  dmem_lsu dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .RspValid(RspValid), .RspReady(RspReady),
    .RspData(RspData), .RspAddr(RspAddr), .RspLast(RspLast), .RspErr(RspErr),
`ifdef DMEM_LSU_STATS_EN
    .LoadCount(LoadCount), .StoreCount(StoreCount),
`endif
    .MemReadSelect(MemReadSelect), .MemDataOut(MemDataOut), .MemWriteEn(MemWriteEn),
    .MemWriteSelect(MemWriteSelect), .MemDataIn(MemDataIn)
  );
  assign MemDataOut = mem[MemReadSelect];
  always @(posedge Clock) if (MemWriteEn) mem[MemWriteSelect] <= MemDataIn;
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
    ReqValid = 1'b1;
    ReqOp = op;
    ReqAddr = a;
    ReqData = d;
    tick();
    ReqValid = 1'b0;
  endtask
  task automatic dump_run(input bit toggle);
    int beat = 0;
    bit rr = 1'b0;
    issue(OP_DUMP, 4'h7, 8'h00);
    for (int c = 0; c < 200 && beat < 16; c++) begin
      rr = toggle ? ~rr : 1'b1;
      RspReady = rr;
      if (RspValid && RspReady) begin
        chk("dump_addr", RspAddr, beat);
        chk("dump_data", RspData, exp_mem[beat]);
        chk("dump_last", RspLast, beat == 15);
        beat++;
      end
      tick();
    end
    chk("dump_beats", beat, 16);
    chk("dump_idle_ready", ReqReady, 1);
    chk("dump_idle_valid", RspValid, 0);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'(i + 8'h10);
      exp_mem[i] = 8'(i + 8'h10);
    end
    Reset = 1'b1;
    ReqValid = 1'b0;
    ReqOp = 2'b00;
    ReqAddr = '0;
    ReqData = '0;
    RspReady = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", ReqReady, 1);
    chk("rst_rsp_valid", RspValid, 0);
    chk("rst_we", MemWriteEn, 0);
    chk("rst_last_err", {RspLast, RspErr}, 0);
    chk("rst_rd_sel", MemReadSelect, 0);
    Reset = 1'b0;
    tick();
    RspReady = 1'b1;
    issue(OP_LOAD, 4'h3, 8'h00);
    chk("load_busy", {ReqReady, RspValid}, 2'b00);
    tick();
    chk("load_valid", RspValid, 1);
    chk("load_data", RspData, 8'h13);
    chk("load_addr", RspAddr, 4'h3);
    chk("load_last_err", {RspLast, RspErr}, 2'b10);
    tick();
    chk("load_done", {ReqReady, RspValid}, 2'b10);
    issue(OP_STORE, 4'hA, 8'h5C);
    exp_mem[10] = 8'h5C;
    chk("store_we", MemWriteEn, 1);
    chk("store_sel", MemWriteSelect, 4'hA);
    chk("store_din", MemDataIn, 8'h5C);
    chk("store_busy", ReqReady, 0);
    chk("store_no_rsp", RspValid, 0);
    tick();
    chk("store_we_off", MemWriteEn, 0);
    chk("store_ready", ReqReady, 1);
    chk("store_commit", mem[10], 8'h5C);
    issue(OP_LOAD, 4'hA, 8'h00);
    tick();
    chk("raw_valid", RspValid, 1);
    chk("raw_data", RspData, 8'h5C);
    tick();
    dump_run(1'b1);
    RspReady = 1'b0;
    issue(OP_RSVD, 4'h5, 8'hFF);
    chk("rsvd_valid", RspValid, 1);
    chk("rsvd_err", RspErr, 1);
    chk("rsvd_data", RspData, 8'h00);
    chk("rsvd_last", RspLast, 1);
    chk("rsvd_no_we", MemWriteEn, 0);
    tick();
    chk("rsvd_hold", {RspValid, RspErr, RspLast}, 3'b111);
    RspReady = 1'b1;
    tick();
    chk("rsvd_done", {ReqReady, RspValid}, 2'b10);
    dump_run(1'b0);
    issue(OP_DUMP, 4'h0, 8'h00);
    tick();
    tick();
    tick();
    Reset = 1'b1;
    tick();
    chk("mid_rst_valid", RspValid, 0);
    chk("mid_rst_last", RspLast, 0);
    chk("mid_rst_ready", ReqReady, 1);
    Reset = 1'b0;
    tick();
    issue(OP_LOAD, 4'h1, 8'h00);
    tick();
    chk("post_rst_load", {RspValid, RspData}, {1'b1, 8'h11});
    tick();
`ifdef DMEM_LSU_STATS_EN
    chk("stats_clear", {LoadCount, StoreCount}, {8'd1, 8'd0});
    for (int i = 0; i < 300; i++) begin
      issue(OP_STORE, 4'(i), 8'(i));
      tick();
    end
    chk("store_count_sat", StoreCount, 8'd255);
    issue(OP_LOAD, 4'h2, 8'h00);
    tick();
    tick();
    issue(OP_LOAD, 4'h4, 8'h00);
    tick();
    tick();
    chk("load_count", LoadCount, 8'd3);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
